// File: rtl/counter_4bit.sv
// Free-running modulo-(MAX_VALUE+1) up-counter with an async active-high reset.
// It provides a combinational terminal-count flag and a registered wrap pulse.
module counter_4bit #(
  parameter int unsigned      WIDTH       = 4,
  parameter logic [WIDTH-1:0] MAX_VALUE   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             wrap
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("counter_4bit: WIDTH must be in 1..32");
  end
  if (MAX_VALUE == '0) begin : g_bad_max
    $error("counter_4bit: MAX_VALUE must be non-zero");
  end
  if (RESET_VALUE > MAX_VALUE) begin : g_bad_reset
    $error("counter_4bit: RESET_VALUE must not exceed MAX_VALUE");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             at_max_c;

  always_comb begin
    at_max_c = (count_q == MAX_VALUE);
    count_d  = at_max_c ? '0 : count_q + 1'b1;
    wrap_d   = at_max_c;
  end

  // Reset wins over counting, including on an edge that coincides with release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RESET_VALUE;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count  = count_q;
  assign at_max = at_max_c;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_counter_4bit.sv
// Directed bench for counter_4bit: default, MAX_VALUE=9 and RESET_VALUE=5 instances
// share one clock and reset and are compared against hand-computed tables.
module tb_counter_4bit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cnt_d, cnt_9, cnt_5;
  logic       am_d, am_9, am_5;
  logic       wr_d, wr_9, wr_5;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  counter_4bit dut_d (
    .clk(clk), .reset(reset), .count(cnt_d), .at_max(am_d), .wrap(wr_d)
  );
  counter_4bit #(.MAX_VALUE(4'd9)) dut_9 (
    .clk(clk), .reset(reset), .count(cnt_9), .at_max(am_9), .wrap(wr_9)
  );
  counter_4bit #(.RESET_VALUE(4'd5)) dut_5 (
    .clk(clk), .reset(reset), .count(cnt_5), .at_max(am_5), .wrap(wr_5)
  );

  typedef struct {
    logic       rst;
    logic [3:0] c_d; logic a_d; logic w_d;
    logic [3:0] c_9; logic a_9; logic w_9;
    logic [3:0] c_5; logic a_5; logic w_5;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst,
                     input logic [3:0] cd, input logic ad, input logic wd,
                     input logic [3:0] c9, input logic a9, input logic w9,
                     input logic [3:0] c5, input logic a5, input logic w5);
    vec_t v;
    v.rst = rst;
    v.c_d = cd; v.a_d = ad; v.w_d = wd;
    v.c_9 = c9; v.a_9 = a9; v.w_9 = w9;
    v.c_5 = c5; v.a_5 = a5; v.w_5 = w5;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, " count"},     int'(cnt_d), int'(v.c_d));
    check({tag, " at_max"},    int'(am_d),  int'(v.a_d));
    check({tag, " wrap"},      int'(wr_d),  int'(v.w_d));
    check({tag, " count9"},    int'(cnt_9), int'(v.c_9));
    check({tag, " at_max9"},   int'(am_9),  int'(v.a_9));
    check({tag, " wrap9"},     int'(wr_9),  int'(v.w_9));
    check({tag, " count_rv5"}, int'(cnt_5), int'(v.c_5));
    check({tag, " at_max_rv5"},int'(am_5),  int'(v.a_5));
    check({tag, " wrap_rv5"},  int'(wr_5),  int'(v.w_5));
  endtask

  initial begin
    vec_t rs;
    int   cyc;
    int   wraps9;

    //     rst  dflt        max9        rv5
    add(1'b1, 4'd0, 0, 0,  4'd0, 0, 0,  4'd5, 0, 0);
    add(1'b0, 4'd1, 0, 0,  4'd1, 0, 0,  4'd6, 0, 0);
    add(1'b0, 4'd2, 0, 0,  4'd2, 0, 0,  4'd7, 0, 0);
    add(1'b0, 4'd3, 0, 0,  4'd3, 0, 0,  4'd8, 0, 0);
    add(1'b0, 4'd4, 0, 0,  4'd4, 0, 0,  4'd9, 0, 0);
    add(1'b0, 4'd5, 0, 0,  4'd5, 0, 0,  4'd10,0, 0);
    add(1'b0, 4'd6, 0, 0,  4'd6, 0, 0,  4'd11,0, 0);
    add(1'b0, 4'd7, 0, 0,  4'd7, 0, 0,  4'd12,0, 0);
    add(1'b0, 4'd8, 0, 0,  4'd8, 0, 0,  4'd13,0, 0);
    add(1'b0, 4'd9, 0, 0,  4'd9, 1, 0,  4'd14,0, 0);
    add(1'b0, 4'd10,0, 0,  4'd0, 0, 1,  4'd15,1, 0);
    add(1'b0, 4'd11,0, 0,  4'd1, 0, 0,  4'd0, 0, 1);
    add(1'b0, 4'd12,0, 0,  4'd2, 0, 0,  4'd1, 0, 0);
    add(1'b0, 4'd13,0, 0,  4'd3, 0, 0,  4'd2, 0, 0);
    add(1'b0, 4'd14,0, 0,  4'd4, 0, 0,  4'd3, 0, 0);
    add(1'b0, 4'd15,1, 0,  4'd5, 0, 0,  4'd4, 0, 0);
    add(1'b0, 4'd0, 0, 1,  4'd6, 0, 0,  4'd5, 0, 0);
    add(1'b0, 4'd1, 0, 0,  4'd7, 0, 0,  4'd6, 0, 0);
    add(1'b0, 4'd2, 0, 0,  4'd8, 0, 0,  4'd7, 0, 0);
    add(1'b0, 4'd3, 0, 0,  4'd9, 1, 0,  4'd8, 0, 0);
    add(1'b0, 4'd4, 0, 0,  4'd0, 0, 1,  4'd9, 0, 0);
    add(1'b1, 4'd0, 0, 0,  4'd0, 0, 0,  4'd5, 0, 0);
    add(1'b0, 4'd1, 0, 0,  4'd1, 0, 0,  4'd6, 0, 0);

    // Reset values before any clock edge.
    reset <= 1'b1;
    #2;
    rs = vecs[0];
    check_all("por", rs);

    // Table: reset input applied on the falling edge, outputs sampled after the rising edge.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset <= vecs[i].rst;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset between edges at count 7, held for three edges.
    cyc = 0;
    while (cnt_d !== 4'd7 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check("reach7", int'(cnt_d), 7);
    #2;
    reset <= 1'b1;
    #1;
    check("async count", int'(cnt_d), 0);
    check("async wrap",  int'(wr_d),  0);
    check("async rv5",   int'(cnt_5), 5);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d count", k), int'(cnt_d), 0);
    end
    @(negedge clk);
    reset <= 1'b0;
    @(posedge clk); #1;
    check("release count", int'(cnt_d), 1);
    check("release rv5",   int'(cnt_5), 6);

    // Asynchronous reset while the wrap pulse is high clears it at once.
    cyc = 0;
    while (wr_d !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check("reach wrap", int'(wr_d), 1);
    check("wrap count", int'(cnt_d), 0);
    #2;
    reset <= 1'b1;
    #1;
    check("async wrap clr", int'(wr_d), 0);

    // Release coincident with a rising edge: that edge still sees reset.
    @(negedge clk);
    @(posedge clk);
    reset <= 1'b0;
    #1;
    check("edge rel count", int'(cnt_d), 0);
    check("edge rel rv5",   int'(cnt_5), 5);
    @(posedge clk); #1;
    check("edge next count", int'(cnt_d), 1);
    check("edge next max9",  int'(cnt_9), 1);
    check("edge next rv5",   int'(cnt_5), 6);

    // Modulo-10 instance over 30 edges: bounded count, flag only at 9, three wraps.
    wraps9 = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (wr_9 === 1'b1) wraps9++;
      check("max9 bound", int'(cnt_9 <= 4'd9), 1);
      check("max9 at_max", int'(am_9), int'(cnt_9 == 4'd9));
    end
    check("max9 wraps", wraps9, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/counter_4bit.md
Name: counter_4bit

Overview:
- Free-running synchronous up-counter with asynchronous active-high reset.
- Increments once per rising clock edge and wraps from its maximum value back to zero.
- Provides status flags for the terminal value and for wrap events.
- General-purpose timing and sequencing block; default configuration is 4-bit, modulo-16.

Parameters:
- WIDTH, 4, bit width of count; legal range 1..32.
- MAX_VALUE, 2**WIDTH-1, terminal value after which count wraps to 0; must satisfy 0 < MAX_VALUE <= 2**WIDTH-1.
- RESET_VALUE, 0, value loaded into count on reset; must be <= MAX_VALUE.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
- count  output  WIDTH  current counter value, driven directly from a register.
- at_max  output  1  combinational flag, high while count == MAX_VALUE.
- wrap  output  1  registered one-cycle pulse, high in the cycle after count transitions MAX_VALUE -> 0.

Behaviour:
- Reset (asynchronous, active-high):
  - While reset=1: count = RESET_VALUE and wrap = 0, immediately, independent of clk.
  - at_max follows count combinationally, so it is 1 only if RESET_VALUE == MAX_VALUE.
  - Reset has priority over counting at every edge.
- Reset release: takes effect at the next rising edge. The first edge with reset=0 produces count = RESET_VALUE+1, or 0 if RESET_VALUE == MAX_VALUE.
- Counting: on each rising clk edge with reset=0:
  - count < MAX_VALUE -> count <= count + 1, wrap <= 0.
  - count == MAX_VALUE -> count <= 0, wrap <= 1.
- Latency: count changes exactly one edge after the condition that drives it; there is no enable or hold state.
- Width/arithmetic: unsigned, modulo (MAX_VALUE+1). count never exceeds MAX_VALUE. No X values are permitted after the first reset assertion.
- Reset mid-count: asserting reset at any time, including between edges, forces count to RESET_VALUE and clears wrap within the same time step. Counting resumes from the first edge after deassertion.
- Reset deasserted coincident with a clk edge: that edge is treated as still in reset, and count stays RESET_VALUE.
- Power-up without reset: outputs are undefined. The system must apply reset before use.
- Outputs are glitch-free: count and wrap come directly from flops; at_max is a single compare of count.

Test Plan:
- Default params; clk period 10 ns, starting at 0; reset=1 for 0-20 ns, then 0 -> count=0 through 20 ns; count=1 at 25 ns, 2 at 35 ns, ... 10 at 115 ns.
- Wrap: run 16 edges after reset release -> count sequence 1..15 then 0. at_max=1 only while count=15. wrap=1 for exactly one cycle, when count=0 after the wrap.
- Async reset mid-run: at count=7, assert reset between edges -> count=0 and wrap=0 immediately. Hold reset for 3 edges -> count stays 0. Release -> count=1 at the next edge.
- Reset released on an edge: deassert reset exactly at a rising edge -> count remains 0 at that edge and becomes 1 at the following edge.
- Non-power-of-2 modulus: MAX_VALUE=9 -> count cycles 0..9 then 0. at_max high at 9. wrap pulses once per 10 cycles. count never exceeds 9.
- RESET_VALUE=5, WIDTH=4 -> count=5 during reset, then 6, 7, ... 15, 0, with wrap pulsing after 15.
